fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//   Read-side drain engine for the sync fifo. Issues read_en against the FIFO's empty flag,
//   absorbs the FIFO's 1-cycle registered read latency, and presents the words as a
//   valid/ready stream through a 2-entry output buffer. Sits between the fifo read port
//   and any downstream consumer; sustains 1 word/cycle with no bubbles.
// PARAMETERS
//   Width   16  data word width; must match the fifo Width
//   CNT_W   16  width of the delivered-word counter (optional feature only)
// PORTS
//   clk          in   1      clock; all logic rising-edge
//   rst          in   1      asynchronous, active-low reset
//   fifo_empty   in   1      fifo empty flag
//   fifo_d_out   in   Width  fifo read data, valid the cycle after a granted read_en
//   fifo_read_en out  1      pop request to fifo
//   m_data       out  Width  stream data
//   m_valid      out  1      stream data valid
//   m_ready      in   1      consumer accept
//   rd_count     out  CNT_W  words delivered (only with FIFO_RD_CNT_EN)
// BEHAVIOUR
//   Reset (rst=0, async): m_valid=0, m_data=0, fifo_read_en=0, occ=0, inflight=0, rd_count=0.
//   occ: output-buffer occupancy 0..2 (FSM states EMPTY/ONE/TWO); inflight: read issued last cycle.
//   pop = m_valid & m_ready. m_valid = (occ!=0). m_data = head entry.
//   fifo_read_en = !fifo_empty & ((occ + inflight - pop) < 2); combinational, depends on m_ready.
//   inflight <= fifo_read_en (registered). When inflight=1, fifo_d_out is captured next edge.
//   Transitions per edge: occ_next = occ + inflight - pop; capture goes to tail, pop drops head.
//     EMPTY: inflight -> ONE; else stay.
//     ONE:   inflight & !pop -> TWO; !inflight & pop -> EMPTY; otherwise stay.
//     TWO:   pop & !inflight -> ONE; pop & inflight -> TWO; !pop -> stay (inflight=0 guaranteed).
//   Latency: first word appears on m_data/m_valid 2 cycles after fifo_empty falls (read_en, then capture).
//   Order preserved strictly; no word dropped or duplicated while rst=1.
//   Overflow impossible by construction: occ+inflight never exceeds 2; assert in sim.
//   Simultaneous capture and pop in ONE: head replaced by captured word, m_valid stays 1.
//   m_ready=0 with occ=2: read_en held 0; m_data/m_valid stable until accepted.
//   m_valid, once high, never drops without pop (no retraction).
//   Reset mid-operation: buffered and in-flight words discarded; fifo must be reset together.
// CONFIGURATION
//   FIFO_RD_CNT_EN defined: rd_count increments by 1 on every pop, wraps 2^CNT_W-1 -> 0.
//   FIFO_RD_CNT_EN undefined: rd_count port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package fifo_rd_pkg: OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2, default Width.
//   Sub-module stream_skid2: 2-entry buffer (push, pop, occ, head); top holds read_en/inflight logic.
// TESTING
//   1 Reset: rst=0 mid-stream with occ=2 -> m_valid=0, fifo_read_en=0, rd_count=0 immediately.
//   2 Streaming: fifo holds 0xAA,0xCC,0xAB, m_ready=1 -> m_data 0xAA,0xCC,0xAB on 3 consecutive
//     cycles, first 2 cycles after empty falls; read_en high 3 consecutive cycles.
//   3 Backpressure: 8 words in fifo, m_ready=0 -> exactly 2 read_en pulses, occ=2, m_data=word0
//     stable; release m_ready -> remaining 8 words out back-to-back, in order.
//   4 Empty boundary: single word 0x1234 -> one read_en, one m_valid beat, then m_valid=0;
//     read_en never asserted while fifo_empty=1.
//   5 Random m_ready (50%) over 1000 words -> scoreboard in-order, no loss; occ+inflight<=2 always.
//   6 FIFO_RD_CNT_EN, CNT_W=4: 17 pops -> rd_count=1 (wrap); without macro, builds without port.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants and occupancy-state encoding for the fifo stream reader.
`timescale 1ns/1ps
package fifo_rd_pkg;
   localparam int unsigned WIDTH_DEFAULT = 16;
   localparam int unsigned CNT_W_DEFAULT = 16;
   localparam int unsigned OCC_W         = 2;
   localparam int unsigned LVL_W         = OCC_W + 1;

   localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
   localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
   localparam logic [OCC_W-1:0] OCC_TWO   = 2'd2;

   typedef enum logic [OCC_W-1:0] {
      ST_EMPTY = OCC_EMPTY,
      ST_ONE   = OCC_ONE,
      ST_TWO   = OCC_TWO
   } occ_state_e;
endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order output buffer; entry 0 is always the head presented downstream.
`timescale 1ns/1ps
module stream_skid2
   import fifo_rd_pkg::*;
#(
   parameter int unsigned Width = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [OCC_W-1:0] occ_o,
   output logic [Width-1:0] head_o
);
   occ_state_e       state_q, state_d;
   logic [Width-1:0] ent0_q, ent0_d;
   logic [Width-1:0] ent1_q, ent1_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
         ent0_q  <= '0;
         ent1_q  <= '0;
      end else begin
         state_q <= state_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
      end
   end

   // Capture lands at the tail, pop shifts the tail into the head.
   always_comb begin
      state_d = state_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (push_i) begin
               state_d = ST_ONE;
               ent0_d  = push_data_i;
            end
         end
         ST_ONE: begin
            if (push_i && pop_i) begin
               ent0_d = push_data_i;
            end else if (push_i) begin
               state_d = ST_TWO;
               ent1_d  = push_data_i;
            end else if (pop_i) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (pop_i) begin
               ent0_d = ent1_q;
               if (push_i) ent1_d = push_data_i;
               else        state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   assign occ_o  = OCC_W'(state_q);
   assign head_o = ent0_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the sync fifo into a valid/ready stream at one word per cycle.
// Optional delivered-word counter (rd_count) enabled by FIFO_RD_CNT_EN.
`timescale 1ns/1ps
module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int unsigned Width = WIDTH_DEFAULT
`ifdef FIFO_RD_CNT_EN
   ,parameter int unsigned CNT_W = CNT_W_DEFAULT
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [Width-1:0] fifo_d_out,
   output logic             fifo_read_en,
   output logic [Width-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
   ,output logic [CNT_W-1:0] rd_count
`endif
);
   logic             inflight_q;
   logic             pop;
   logic [OCC_W-1:0] occ;
   logic [LVL_W-1:0] level;

   stream_skid2 #(.Width(Width)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .push_i     (inflight_q),
      .push_data_i(fifo_d_out),
      .pop_i      (pop),
      .occ_o      (occ),
      .head_o     (m_data)
   );

   assign m_valid = (occ != OCC_EMPTY);
   assign pop     = m_valid & m_ready;

   // Words that will occupy the buffer after this edge; issue only if one slot stays free.
   assign level        = LVL_W'(occ) + LVL_W'(inflight_q) - LVL_W'(pop);
   assign fifo_read_en = rst & ~fifo_empty & (level < LVL_W'(2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) inflight_q <= 1'b0;
      else      inflight_q <= fifo_read_en;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      (LVL_W'(occ) + LVL_W'(inflight_q)) <= LVL_W'(2));

`ifdef FIFO_RD_CNT_EN
   logic [CNT_W-1:0] rd_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     rd_count_q <= '0;
      else if (pop) rd_count_q <= rd_count_q + CNT_W'(1);
   end

   assign rd_count = rd_count_q;
`endif
endmodule
